// File: rtl/vga_write_scheduler_pkg.sv
// Shared VGA write-side definitions: frame geometry defaults,
// colour width and fill FSM encodings.
package vga_write_scheduler_pkg;

  localparam int RESOL_X_DEF     = 100;
  localparam int RESOL_Y_DEF     = 100;
  localparam int ADDR_WIDTH_DEF  = 16;
  localparam int COLOR_WIDTH_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } fill_state_e;

endpackage

// File: rtl/vga_write_scheduler_if.sv
// Request/status bundle between the ALU decode side and the
// VGA frame RAM write scheduler.
interface vga_write_scheduler_if #(
  parameter int ADDR_WIDTH  = 16,
  parameter int COLOR_WIDTH = 3
);
  logic                   iCpuWrite;
  logic [7:0]             iCpuRow;
  logic [7:0]             iCpuCol;
  logic [COLOR_WIDTH-1:0] iCpuColor;
  logic                   iFillStart;
  logic [7:0]             iFillRow0;
  logic [7:0]             iFillCol0;
  logic [7:0]             iFillHeight;
  logic [7:0]             iFillWidth;
  logic [COLOR_WIDTH-1:0] iFillColor;
  logic                   oFillBusy;
  logic                   oFillDone;
  logic                   oOutOfRange;
  logic                   oWriteEnable;
  logic [ADDR_WIDTH-1:0]  oWriteAddress;
  logic [COLOR_WIDTH-1:0] oWriteData;

  modport master (
    output iCpuWrite, iCpuRow, iCpuCol, iCpuColor,
    output iFillStart, iFillRow0, iFillCol0,
    output iFillHeight, iFillWidth, iFillColor,
    input  oFillBusy, oFillDone, oOutOfRange,
    input  oWriteEnable, oWriteAddress, oWriteData
  );

  modport slave (
    input  iCpuWrite, iCpuRow, iCpuCol, iCpuColor,
    input  iFillStart, iFillRow0, iFillCol0,
    input  iFillHeight, iFillWidth, iFillColor,
    output oFillBusy, oFillDone, oOutOfRange,
    output oWriteEnable, oWriteAddress, oWriteData
  );
endinterface

// File: rtl/ffd_posedge_syncronous_reset.sv
// Generic enabled D flip-flop bank with synchronous
// active-high reset.
module FFD_POSEDGE_SYNCRONOUS_RESET #(
  parameter int SIZE = 1
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Enable,
  input  logic [SIZE-1:0] D,
  output logic [SIZE-1:0] Q
);

  always_ff @(posedge Clock) begin
    if (Reset) Q <= '0;
    else if (Enable) Q <= D;
  end

endmodule

// File: rtl/vga_rect_walker.sv
// Rectangle walker: clips the box to the frame and steps
// row-base/column counters one pixel per advance.
module vga_rect_walker
  import vga_write_scheduler_pkg::*;
#(
  parameter int RESOL_X    = RESOL_X_DEF,
  parameter int RESOL_Y    = RESOL_Y_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iStart,
  input  logic [7:0]            iRow0,
  input  logic [7:0]            iCol0,
  input  logic [7:0]            iHeight,
  input  logic [7:0]            iWidth,
  input  logic                  iAdvance,
  output logic [ADDR_WIDTH-1:0] oAddr,
  output logic                  oLast,
  output logic                  oEmpty
);

  localparam int PW = ADDR_WIDTH + 8;

  logic [ADDR_WIDTH-1:0] row_base_q;
  logic [7:0]            cur_col_q;
  logic [7:0]            col0_q;
  logic [7:0]            h_q;
  logic [7:0]            w_q;
  logic [7:0]            row_cnt_q;
  logic [7:0]            col_cnt_q;

  int                    row_room;
  int                    col_room;
  logic [7:0]            h_clip;
  logic [7:0]            w_clip;
  logic [ADDR_WIDTH-1:0] base0;
  logic                  row_end;

  always_comb begin
    row_room = RESOL_Y - int'(iRow0);
    col_room = RESOL_X - int'(iCol0);
    h_clip = iHeight;
    w_clip = iWidth;
    if (int'(iHeight) > row_room) h_clip = 8'(row_room);
    if (int'(iWidth) > col_room) w_clip = 8'(col_room);
    oEmpty = (int'(iRow0) >= RESOL_Y)
           | (int'(iCol0) >= RESOL_X)
           | (iHeight == 8'd0)
           | (iWidth == 8'd0);
    base0 = ADDR_WIDTH'(PW'(iRow0) * PW'(RESOL_X));
  end

  assign row_end = (col_cnt_q == w_q - 8'd1);
  assign oLast   = row_end && (row_cnt_q == h_q - 8'd1);
  assign oAddr   = row_base_q + ADDR_WIDTH'(cur_col_q);

  // Row stepping is additive so the loop needs no multiplier.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      row_base_q <= '0;
      cur_col_q  <= '0;
      col0_q     <= '0;
      h_q        <= '0;
      w_q        <= '0;
      row_cnt_q  <= '0;
      col_cnt_q  <= '0;
    end else if (iStart) begin
      row_base_q <= base0;
      cur_col_q  <= iCol0;
      col0_q     <= iCol0;
      h_q        <= h_clip;
      w_q        <= w_clip;
      row_cnt_q  <= '0;
      col_cnt_q  <= '0;
    end else if (iAdvance) begin
      if (row_end) begin
        row_base_q <= row_base_q + ADDR_WIDTH'(RESOL_X);
        cur_col_q  <= col0_q;
        col_cnt_q  <= '0;
        row_cnt_q  <= row_cnt_q + 8'd1;
      end else begin
        cur_col_q  <= cur_col_q + 8'd1;
        col_cnt_q  <= col_cnt_q + 8'd1;
      end
    end
  end

endmodule

// File: rtl/vga_write_scheduler.sv
// Frame RAM write-port owner: CPU pixel writes take priority,
// the rectangle fill engine uses every remaining cycle.
module vga_write_scheduler
  import vga_write_scheduler_pkg::*;
#(
  parameter int RESOL_X     = RESOL_X_DEF,
  parameter int RESOL_Y     = RESOL_Y_DEF,
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int COLOR_WIDTH = COLOR_WIDTH_DEF
) (
  input logic Clock,
  input logic Reset,
  vga_write_scheduler_if.slave bus
);

  localparam int PW = ADDR_WIDTH + 8;
  localparam int OW = 2 + ADDR_WIDTH + COLOR_WIDTH;

  fill_state_e            state_q;
  logic [COLOR_WIDTH-1:0] color_q;
  logic                   busy_q;
  logic                   done_q;

  logic                   cpu_ok;
  logic                   grant;
  logic                   start;
  logic                   last;
  logic                   empty;
  logic [ADDR_WIDTH-1:0]  walk_addr;
  logic [ADDR_WIDTH-1:0]  cpu_addr;

  logic                   we_d;
  logic                   oor_d;
  logic [ADDR_WIDTH-1:0]  addr_d;
  logic [COLOR_WIDTH-1:0] data_d;
  logic [OW-1:0]          out_q;

  assign cpu_ok = bus.iCpuWrite
                & (int'(bus.iCpuRow) < RESOL_Y)
                & (int'(bus.iCpuCol) < RESOL_X);
  assign grant  = (state_q == ST_FILL) & ~cpu_ok;
  assign start  = (state_q == ST_IDLE) & bus.iFillStart;
  assign oor_d  = bus.iCpuWrite & ~cpu_ok;

  assign cpu_addr = ADDR_WIDTH'(
    PW'(bus.iCpuRow) * PW'(RESOL_X) + PW'(bus.iCpuCol));

  vga_rect_walker #(
    .RESOL_X    (RESOL_X),
    .RESOL_Y    (RESOL_Y),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_walker (
    .Clock    (Clock),
    .Reset    (Reset),
    .iStart   (start),
    .iRow0    (bus.iFillRow0),
    .iCol0    (bus.iFillCol0),
    .iHeight  (bus.iFillHeight),
    .iWidth   (bus.iFillWidth),
    .iAdvance (grant),
    .oAddr    (walk_addr),
    .oLast    (last),
    .oEmpty   (empty)
  );

  always_comb begin
    we_d   = 1'b0;
    addr_d = '0;
    data_d = '0;
    unique case (1'b1)
      cpu_ok: begin
        we_d   = 1'b1;
        addr_d = cpu_addr;
        data_d = bus.iCpuColor;
      end
      grant: begin
        we_d   = 1'b1;
        addr_d = walk_addr;
        data_d = color_q;
      end
      default: ;
    endcase
  end

  // Done is raised on the same edge that registers the last pixel.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      color_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (bus.iFillStart) begin
          color_q <= bus.iFillColor;
          busy_q  <= 1'b1;
          if (empty) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_FILL;
          end
        end
        ST_FILL: if (grant && last) begin
          state_q <= ST_DONE;
          done_q  <= 1'b1;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  FFD_POSEDGE_SYNCRONOUS_RESET #(
    .SIZE (OW)
  ) u_out_ff (
    .Clock  (Clock),
    .Reset  (Reset),
    .Enable (1'b1),
    .D      ({we_d, oor_d, addr_d, data_d}),
    .Q      (out_q)
  );

  assign bus.oWriteEnable  = out_q[OW-1];
  assign bus.oOutOfRange   = out_q[OW-2];
  assign bus.oWriteAddress = out_q[COLOR_WIDTH +: ADDR_WIDTH];
  assign bus.oWriteData    = out_q[COLOR_WIDTH-1:0];
  assign bus.oFillBusy     = busy_q;
  assign bus.oFillDone     = done_q;

endmodule

// File: tb/tb_vga_write_scheduler.sv
// Scoreboard bench for vga_write_scheduler: directed CPU writes,
// fills, contention, clipping, mid-fill restart and reset.
module tb_vga_write_scheduler;

  localparam int AW = 16;
  localparam int CW = 3;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [CW-1:0] data;
    logic          done;
    logic          oor;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_write_scheduler_if #(
    .ADDR_WIDTH  (AW),
    .COLOR_WIDTH (CW)
  ) bus ();

  vga_write_scheduler #(
    .RESOL_X     (100),
    .RESOL_Y     (100),
    .ADDR_WIDTH  (AW),
    .COLOR_WIDTH (CW)
  ) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  function automatic ev_t wr(int a, int d, bit dn);
    ev_t e;
    e.we   = 1'b1;
    e.addr = AW'(a);
    e.data = CW'(d);
    e.done = dn;
    e.oor  = 1'b0;
    return e;
  endfunction

  function automatic ev_t flag(bit dn, bit oor);
    ev_t e;
    e      = '0;
    e.done = dn;
    e.oor  = oor;
    return e;
  endfunction

  always @(negedge clk) begin
    ev_t o;
    ev_t e;
    if (bus.oWriteEnable === 1'b1 || bus.oFillDone === 1'b1 ||
        bus.oOutOfRange === 1'b1) begin
      o.we   = bus.oWriteEnable;
      o.addr = bus.oWriteEnable ? bus.oWriteAddress : '0;
      o.data = bus.oWriteEnable ? bus.oWriteData : '0;
      o.done = bus.oFillDone;
      o.oor  = bus.oOutOfRange;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event: got we=%b addr=%0d data=%b done=%b oor=%b, required none",
                 o.we, o.addr, o.data, o.done, o.oor);
      end else begin
        e = exp_q.pop_front();
        if (o !== e) begin
          n_bad++;
          $display("FAIL event @%0t: got we=%b addr=%0d data=%b done=%b oor=%b, required we=%b addr=%0d data=%b done=%b oor=%b",
                   $time, o.we, o.addr, o.data, o.done, o.oor,
                   e.we, e.addr, e.data, e.done, e.oor);
        end
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic cpu(int r, int c, int col);
    bus.iCpuWrite = 1'b1;
    bus.iCpuRow   = 8'(r);
    bus.iCpuCol   = 8'(c);
    bus.iCpuColor = CW'(col);
    cyc();
    bus.iCpuWrite = 1'b0;
  endtask

  task automatic fill(int r0, int c0, int h, int w, int col);
    bus.iFillStart  = 1'b1;
    bus.iFillRow0   = 8'(r0);
    bus.iFillCol0   = 8'(c0);
    bus.iFillHeight = 8'(h);
    bus.iFillWidth  = 8'(w);
    bus.iFillColor  = CW'(col);
    cyc();
    bus.iFillStart  = 1'b0;
  endtask

  task automatic wait_idle(string nm, int bound);
    for (int i = 0; i < bound && bus.oFillBusy !== 1'b0; i++) cyc();
    chk(nm, 32'(bus.oFillBusy), 32'd0);
  endtask

  initial begin
    bus.iCpuWrite   = 1'b0;
    bus.iCpuRow     = '0;
    bus.iCpuCol     = '0;
    bus.iCpuColor   = '0;
    bus.iFillStart  = 1'b0;
    bus.iFillRow0   = '0;
    bus.iFillCol0   = '0;
    bus.iFillHeight = '0;
    bus.iFillWidth  = '0;
    bus.iFillColor  = '0;
    repeat (3) cyc();
    chk("rst_we", 32'(bus.oWriteEnable), 0);
    chk("rst_busy", 32'(bus.oFillBusy), 0);
    chk("rst_done", 32'(bus.oFillDone), 0);
    chk("rst_oor", 32'(bus.oOutOfRange), 0);
    rst = 1'b0;
    cyc();

    // single CPU writes, incl. the last on-screen pixel
    exp_q.push_back(wr(203, 5, 0));
    cpu(2, 3, 5);
    exp_q.push_back(wr(9999, 6, 0));
    cpu(99, 99, 6);
    repeat (3) cyc();

    // clipped 2x2 fill
    exp_q.push_back(wr(198, 2, 0));
    exp_q.push_back(wr(199, 2, 0));
    exp_q.push_back(wr(298, 2, 0));
    exp_q.push_back(wr(299, 2, 1));
    fill(1, 98, 2, 5, 2);
    chk("t2_busy_rise", 32'(bus.oFillBusy), 1);
    repeat (4) cyc();
    chk("t2_busy_done", 32'(bus.oFillBusy), 1);
    cyc();
    chk("t2_busy_fall", 32'(bus.oFillBusy), 0);
    cyc();

    // CPU write steals the second fill pixel slot
    exp_q.push_back(wr(198, 2, 0));
    exp_q.push_back(wr(0, 7, 0));
    exp_q.push_back(wr(199, 2, 0));
    exp_q.push_back(wr(298, 2, 0));
    exp_q.push_back(wr(299, 2, 1));
    fill(1, 98, 2, 5, 2);
    cyc();
    cpu(0, 0, 7);
    repeat (3) cyc();
    chk("t3_busy_done", 32'(bus.oFillBusy), 1);
    cyc();
    chk("t3_busy_fall", 32'(bus.oFillBusy), 0);
    cyc();

    // off-screen CPU writes and degenerate fills
    exp_q.push_back(flag(0, 1));
    cpu(100, 5, 1);
    exp_q.push_back(flag(0, 1));
    cpu(0, 100, 1);
    repeat (2) cyc();
    exp_q.push_back(flag(1, 0));
    fill(10, 10, 0, 5, 3);
    chk("t4_h0_busy", 32'(bus.oFillBusy), 1);
    cyc();
    chk("t4_h0_idle", 32'(bus.oFillBusy), 0);
    exp_q.push_back(flag(1, 0));
    fill(100, 0, 4, 4, 1);
    chk("t4_r0_busy", 32'(bus.oFillBusy), 1);
    cyc();
    chk("t4_r0_idle", 32'(bus.oFillBusy), 0);
    repeat (2) cyc();
    chk("t4_drain", 32'(exp_q.size()), 0);

    // full-frame fill with an ignored restart request
    for (int i = 0; i < 10000; i++)
      exp_q.push_back(wr(i, 4, i == 9999));
    fill(0, 0, 100, 100, 4);
    repeat (500) cyc();
    fill(50, 50, 10, 10, 1);
    chk("t5_busy_mid", 32'(bus.oFillBusy), 1);
    wait_idle("t5_timeout", 10100);
    repeat (2) cyc();
    chk("t5_drain", 32'(exp_q.size()), 0);

    // reset mid-fill after 50 pixels, then a fresh fill
    for (int i = 0; i < 50; i++)
      exp_q.push_back(wr(i, 6, 0));
    fill(0, 0, 100, 100, 6);
    repeat (50) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t6_we", 32'(bus.oWriteEnable), 0);
    chk("t6_busy", 32'(bus.oFillBusy), 0);
    chk("t6_done", 32'(bus.oFillDone), 0);
    exp_q.push_back(wr(510, 3, 0));
    exp_q.push_back(wr(511, 3, 0));
    exp_q.push_back(wr(512, 3, 0));
    exp_q.push_back(wr(610, 3, 0));
    exp_q.push_back(wr(611, 3, 0));
    exp_q.push_back(wr(612, 3, 1));
    fill(5, 10, 2, 3, 3);
    wait_idle("t6_timeout", 50);
    repeat (2) cyc();
    chk("final_drain", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
